// File: rtl/rover_pkg.sv
// Shared encodings for the colour-sensor front end: colours, scan states, filter selects.
package rover_pkg;

  typedef enum logic [1:0] {
    COL_NONE  = 2'd0,
    COL_RED   = 2'd1,
    COL_GREEN = 2'd2,
    COL_BLUE  = 2'd3
  } color_e;

  typedef enum logic [1:0] {
    SEL_RED   = 2'd0,
    SEL_BLUE  = 2'd1,
    SEL_GREEN = 2'd2,
    DECIDE    = 2'd3
  } state_e;

  // {s2,s3} photodiode filter selects
  localparam logic [1:0] FILT_RED   = 2'b00;
  localparam logic [1:0] FILT_BLUE  = 2'b01;
  localparam logic [1:0] FILT_GREEN = 2'b11;

  // Strict winner with a minimum count; any tie for the top slot yields NONE.
  function automatic color_e pick_color(input logic [31:0] r, input logic [31:0] g,
                                        input logic [31:0] b, input logic [31:0] min_cnt);
    if (r > g && r > b && r >= min_cnt) return COL_RED;
    if (g > r && g > b && g >= min_cnt) return COL_GREEN;
    if (b > r && b > g && b >= min_cnt) return COL_BLUE;
    return COL_NONE;
  endfunction

endpackage

// File: rtl/pulse_counter.sv
// Synchronizes the asynchronous sensor output and counts its rising edges, saturating.
module pulse_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in,
  input  logic             enable,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  // [0],[1] form the synchronizer; [2] holds the previous synced value
  logic [2:0]       sync_q;
  logic [CNT_W-1:0] count_q;
  logic             rise;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[1:0], in};
  end

  assign rise = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                              count_q <= '0;
    else if (clear)                            count_q <= '0;
    else if (enable && rise && count_q != '1)  count_q <= count_q + 1'b1;
  end

  assign count = count_q;

endmodule

// File: rtl/color_detect.sv
// TCS3200 colour scanner: counts edges under each filter, picks a winner, debounces over two frames.
module color_detect
  import rover_pkg::*;
#(
  parameter int GATE_CYCLES   = 100000,
  parameter int SETTLE_CYCLES = 1000,
  parameter int MIN_COUNT     = 50,
  parameter int CNT_W         = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic sensor_out,
  output logic s2,
  output logic s3,
  output logic Red,
  output logic Green,
  output logic Blue,
  output logic sample_valid
);

  localparam int SEL_CYCLES = SETTLE_CYCLES + GATE_CYCLES;
  localparam int TMR_W      = $clog2(SEL_CYCLES + 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             sel_last;
  logic [1:0]       filt;
  logic             cnt_en, cnt_clr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] r_cnt_q, b_cnt_q;
  color_e           cand, prev_cand_q, color_q;
  logic             sample_valid_q;

  assign sel_last = (timer_q == TMR_W'(SEL_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEL_RED;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      SEL_RED, SEL_BLUE, SEL_GREEN: begin
        if (sel_last) begin
          timer_d = '0;
          state_d = (state_q == SEL_RED)  ? SEL_BLUE  :
                    (state_q == SEL_BLUE) ? SEL_GREEN : DECIDE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DECIDE: begin
        state_d = SEL_RED;
        timer_d = '0;
      end
      default: state_d = SEL_RED;
    endcase
  end

  always_comb begin
    filt    = FILT_GREEN;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    unique case (state_q)
      SEL_RED:   filt = FILT_RED;
      SEL_BLUE:  filt = FILT_BLUE;
      SEL_GREEN: filt = FILT_GREEN;
      default:   filt = FILT_GREEN;  // DECIDE only ever follows SEL_GREEN
    endcase
    if (state_q != DECIDE) begin
      cnt_clr = (timer_q == '0);
      cnt_en  = (timer_q >= TMR_W'(SETTLE_CYCLES));
    end
  end

  assign {s2, s3} = filt;

  pulse_counter #(.CNT_W(CNT_W)) u_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .in      (sensor_out),
    .enable  (cnt_en),
    .clear   (cnt_clr),
    .count   (count)
  );

  // The counter keeps its final value until the next state's first cycle clears it,
  // so each window is captured there; green is still live in the counter during DECIDE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      if (state_q == SEL_BLUE  && timer_q == '0) r_cnt_q <= count;
      if (state_q == SEL_GREEN && timer_q == '0) b_cnt_q <= count;
    end
  end

  assign cand = pick_color(32'(r_cnt_q), 32'(count), 32'(b_cnt_q), 32'(MIN_COUNT));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_cand_q    <= COL_NONE;
      color_q        <= COL_NONE;
      sample_valid_q <= 1'b0;
    end else begin
      sample_valid_q <= (state_q == DECIDE);
      if (state_q == DECIDE) begin
        prev_cand_q <= cand;
        if (cand == prev_cand_q) color_q <= cand;
      end
    end
  end

  assign Red          = (color_q == COL_RED);
  assign Green        = (color_q == COL_GREEN);
  assign Blue         = (color_q == COL_BLUE);
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_color_detect.sv
// Bench for color_detect: directed frames plus random ones, two instances (8-bit and 5-bit counters).
module tb_color_detect;

  localparam int GATE   = 100;
  localparam int SETTLE = 10;
  localparam int MINC   = 5;
  localparam int SEL    = SETTLE + GATE;
  localparam int FRAME  = 3 * SEL + 1;
  localparam int NONE = 0, RED = 1, GREEN = 2, BLUE = 3;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic sensor_out = 1'b0;
  logic s2_a, s3_a, r_a, g_a, b_a, sv_a;
  logic s2_b, s3_b, r_b, g_b, b_b, sv_b;

  color_detect #(.GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .MIN_COUNT(MINC), .CNT_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .sensor_out(sensor_out), .s2(s2_a), .s3(s3_a),
    .Red(r_a), .Green(g_a), .Blue(b_a), .sample_valid(sv_a));

  // Narrow counter so a fast input reaches saturation inside one window
  color_detect #(.GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .MIN_COUNT(MINC), .CNT_W(5)) dut_s (
    .clock(clock), .reset_n(reset_n), .sensor_out(sensor_out), .s2(s2_b), .s3(s3_b),
    .Red(r_b), .Green(g_b), .Blue(b_b), .sample_valid(sv_b));

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int gc = 0;          // cycles since reset release
  bit hist[$];         // sensor value driven in each cycle since release
  int prev_c[2];
  int out_c[2];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp3(input int c);
    return {c == RED, c == GREEN, c == BLUE};
  endfunction

  function automatic bit hv(input int i);
    return (i < 0) ? 1'b0 : hist[i];
  endfunction

  // Input rise driven in cycle k is seen by the counter in cycle k+2 (two sync flops)
  function automatic int win_edges(input int lo, input int hi, input int maxv);
    int n = 0;
    for (int j = lo; j <= hi; j++) if (hv(j - 2) && !hv(j - 3)) n++;
    return (n > maxv) ? maxv : n;
  endfunction

  function automatic int best(input int r, input int g, input int b);
    if (r > g && r > b && r >= MINC) return RED;
    if (g > r && g > b && g >= MINC) return GREEN;
    if (b > r && b > g && b >= MINC) return BLUE;
    return NONE;
  endfunction

  task automatic model_decide(input int base);
    for (int d = 0; d < 2; d++) begin
      int maxv = (d == 0) ? 255 : 31;
      int r = win_edges(base + SETTLE,           base + SEL - 1,     maxv);
      int b = win_edges(base + SEL + SETTLE,     base + 2 * SEL - 1, maxv);
      int g = win_edges(base + 2 * SEL + SETTLE, base + 3 * SEL - 1, maxv);
      int c = best(r, g, b);
      if (c == prev_c[d]) out_c[d] = c;
      prev_c[d] = c;
    end
  endtask

  function automatic bit drive(input int p, input int hr, input int hb, input int hg, input bit so);
    int w = p / SEL;
    int t = p - w * SEL;
    int hp;
    if (w == 3) return 1'b0;
    if (so) return (t < 7) && ((t % 2) == 1);
    hp = (w == 0) ? hr : (w == 1) ? hb : hg;
    if (hp == 0) return 1'b0;
    return ((t / hp) % 2) == 1;
  endfunction

  task automatic check_cycle();
    int p = gc % FRAME;
    logic [1:0] ef = (p < SEL) ? 2'b00 : (p < 2 * SEL) ? 2'b01 : 2'b11;
    logic esv = (gc > 0 && p == 0);
    if (esv) model_decide(gc - FRAME);
    chk("sv_a",   8'(sv_a),               8'(esv));
    chk("rgb_a",  8'({r_a, g_a, b_a}),    8'(exp3(out_c[0])));
    chk("filt_a", 8'({s2_a, s3_a}),       8'(ef));
    chk("sv_b",   8'(sv_b),               8'(esv));
    chk("rgb_b",  8'({r_b, g_b, b_b}),    8'(exp3(out_c[1])));
    chk("filt_b", 8'({s2_b, s3_b}),       8'(ef));
  endtask

  task automatic run_cycle(input int hr, input int hb, input int hg, input bit so);
    bit v = drive(gc % FRAME, hr, hb, hg, so);
    sensor_out = v;
    hist.push_back(v);
    @(posedge clock);
    @(negedge clock);
    gc++;
    check_cycle();
  endtask

  task automatic run_frames(input int n, input int hr, input int hb, input int hg, input bit so);
    for (int i = 0; i < n * FRAME; i++) run_cycle(hr, hb, hg, so);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rgb_a"},  8'({r_a, g_a, b_a}),  8'd0);
    chk({tag, "_filt_a"}, 8'({s2_a, s3_a}),     8'd0);
    chk({tag, "_sv_a"},   8'(sv_a),             8'd0);
    chk({tag, "_rgb_b"},  8'({r_b, g_b, b_b}),  8'd0);
    chk({tag, "_filt_b"}, 8'({s2_b, s3_b}),     8'd0);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_zero({tag, "_async"});
    @(negedge clock);
    @(negedge clock);
    check_zero({tag, "_held"});
    sensor_out = 1'b0;
    hist.delete();
    gc = 0;
    for (int d = 0; d < 2; d++) begin prev_c[d] = NONE; out_c[d] = NONE; end
    reset_n = 1'b1;
  endtask

  initial begin
    apply_reset("por");

    // Red dominant: first decision only primes the debounce, second commits
    run_frames(1, 2, 6, 8, 1'b0);
    chk("red_f1", 8'({r_a, g_a, b_a}), 8'b000);
    run_frames(1, 2, 6, 8, 1'b0);
    chk("red_f2", 8'({r_a, g_a, b_a}), 8'b100);

    // Saturation: red toggles every cycle (50 edges); blue gives 25
    run_frames(2, 1, 2, 8, 1'b0);
    chk("sat_a", 8'({r_a, g_a, b_a}), 8'b100);
    chk("sat_b", 8'({r_b, g_b, b_b}), 8'b100);

    // Abort mid-frame while in the blue window
    while (gc % FRAME != SEL + 40) run_cycle(2, 6, 8, 1'b0);
    chk("pre_rst", 8'({r_a, g_a, b_a}), 8'b100);
    apply_reset("mid");

    // Tie between red and green
    run_frames(2, 3, 16, 3, 1'b0);
    chk("tie", 8'({r_a, g_a, b_a}), 8'b000);

    // Green latched, then below threshold: held one frame, cleared on the second
    run_frames(2, 8, 8, 2, 1'b0);
    chk("grn_set", 8'({r_a, g_a, b_a}), 8'b010);
    run_frames(1, 12, 12, 12, 1'b0);
    chk("low_f1", 8'({r_a, g_a, b_a}), 8'b010);
    run_frames(1, 12, 12, 12, 1'b0);
    chk("low_f2", 8'({r_a, g_a, b_a}), 8'b000);

    // Blue, then edges only inside settle periods
    run_frames(2, 8, 2, 8, 1'b0);
    chk("blu_set", 8'({r_a, g_a, b_a}), 8'b001);
    run_frames(2, 0, 0, 0, 1'b1);
    chk("settle", 8'({r_a, g_a, b_a}), 8'b000);

    for (int f = 0; f < 8; f++)
      run_frames(1, $urandom_range(12, 0), $urandom_range(12, 0), $urandom_range(12, 0), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
